vga_capture_monitor: RTL and testbench
======================================

// Module: vga_capture_monitor
// PURPOSE
//   Receive end of the 640x480 VGA interface: samples hsync/vsync/RGB on pix_en, locks to the
//   800x521 raster, recovers active-area pixel coordinates, flags timing errors. Accumulates a
//   per-frame bounding box and count of lit (non-black) pixels. Used as the on-chip checker for
//   the video generator and as the frame-level source for sprite-position self-test.
// PARAMETERS
//   HPIXELS  800  pix_en ticks per line
//   VLINES   521  lines per frame
//   HBP      144  first active hc;  HFP 784  first hc after active
//   VBP      31   first active vc;  VFP 511  first vc after active
// PORTS
//   clk         in   1   100 MHz system clock
//   rst         in   1   synchronous, active-high reset
//   pix_en      in   1   one-clk pixel strobe (25 MHz rate); inputs below valid only when high
//   hsync       in   1   horizontal sync, active low
//   vsync       in   1   vertical sync, active low
//   red/green   in   3/3 pixel colour;  blue in 2
//   locked      out  1   raster lock achieved
//   pix_valid   out  1   one-clk pulse: pix_x/pix_y/pix_rgb hold an active pixel
//   pix_x       out  10  0..639;  pix_y out 10  0..479
//   pix_rgb     out  8   {red,green,blue} of that pixel
//   frame_done  out  1   one-clk pulse: bbox_* and lit_count updated
//   bbox_valid  out  1   last frame had >=1 lit pixel
//   bbox_xmin/xmax/ymin/ymax out 10 each, active-area coordinates, inclusive
//   lit_count   out  19  lit pixels in last frame (max 307200, no saturation needed)
//   err_sync    out  1   one-clk pulse: timing violation, lock dropped
// BEHAVIOUR
//   - All state advances only on clk edges with pix_en=1; pix_en=0 cycles hold everything
//     except single-clk pulses (pix_valid, frame_done, err_sync), which clear next clk.
//   - Reset: every output 0, FSM=SEARCH, counters/accumulators 0. Reset mid-frame discards
//     the partial frame; no frame_done is emitted for it.
//   - Edge detect: hs_q/vs_q = previous pix_en sample. hfall = !hsync & hs_q; vfall = !vsync & vs_q.
//   - Counters (10 b): on hfall hc<=0, else hc<=hc+1. On hfall: vc<=0 if vfall, else vc+1.
//     The sample with hfall is hc=0 (first hsync-low tick of the generator).
//   - FSM SEARCH: wait for vfall&hfall -> MEASURE (hc=vc=0). vfall without hfall: stay.
//   - MEASURE: one full frame, no outputs. Each hfall requires prior hc==HPIXELS-1; each vfall
//     requires prior vc==VLINES-1. On next valid vfall -> LOCKED (locked<=1). Any violation
//     -> SEARCH, no err_sync (not yet locked).
//   - LOCKED violations, each -> err_sync pulse, locked<=0, FSM=SEARCH, accumulators cleared:
//     hfall with hc!=HPIXELS-1; hc==HPIXELS-1 and next sample not hfall; vfall without hfall;
//     vfall with vc!=VLINES-1; vc==VLINES-1 at line end and next line start not vfall.
//   - Active pixel: LOCKED, HBP<=hc<HFP, VBP<=vc<VFP. Registered one clk after the pix_en
//     sample: pix_valid=1, pix_x=hc-HBP, pix_y=vc-VBP, pix_rgb={r,g,b}. pix_x/y/rgb hold otherwise.
//   - Lit = active pixel with {r,g,b}!=0: lit_count_acc+1; xmin/ymin take min, xmax/ymax max.
//     First lit pixel of a frame loads all four directly.
//   - In LOCKED, each valid vfall closes the frame: same clk latch bbox_*, lit_count,
//     bbox_valid=(acc>0), pulse frame_done, clear accumulators. No lit pixels: bbox_* = 0.
//     The MEASURE->LOCKED vfall opens the first frame; it emits no frame_done.
//   - Simultaneous vfall and lit pixel cannot occur (vfall at hc=0, outside active); no
//     priority rule required. err_sync and frame_done never pulse together.
// TESTING
//   1 rst=1 3 clks, then idle syncs high -> all outputs 0, locked=0 throughout.
//   2 Nominal raster (pix_en 1-in-4, all black) -> locked=1 at 2nd vfall; 307200 pix_valid per
//     frame; first pix_x=0,pix_y=0, last pix_x=639,pix_y=479; frame_done with lit_count=0, bbox_valid=0.
//   3 White 16x16 block at hc 464..479, vc 255..270 -> bbox_xmin=320,xmax=335,ymin=224,
//     ymax=239, lit_count=256, bbox_valid=1 at the closing vfall.
//   4 Locked, one line shortened to 799 ticks -> err_sync 1 clk, locked=0, relock 2 frames later.
//   5 Locked, frame of 520 lines -> err_sync at early vfall; no frame_done for that frame.
//   6 rst=1 for 1 clk mid-frame with lit pixels -> outputs 0, next frame_done only after relock.

Source files
------------

// File: rtl/vga_capture_monitor.sv
// VGA receive-side monitor: locks to the raster, recovers active-area pixel coordinates,
// flags sync timing errors and reports a per-frame lit-pixel bounding box and count.
module vga_capture_monitor #(
    parameter int HPIXELS = 800,
    parameter int VLINES  = 521,
    parameter int HBP     = 144,
    parameter int HFP     = 784,
    parameter int VBP     = 31,
    parameter int VFP     = 511
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_en,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic [2:0]  i_red,
    input  logic [2:0]  i_green,
    input  logic [1:0]  i_blue,
    output logic        o_locked,
    output logic        o_pix_valid,
    output logic [9:0]  o_pix_x,
    output logic [9:0]  o_pix_y,
    output logic [7:0]  o_pix_rgb,
    output logic        o_frame_done,
    output logic        o_bbox_valid,
    output logic [9:0]  o_bbox_xmin,
    output logic [9:0]  o_bbox_xmax,
    output logic [9:0]  o_bbox_ymin,
    output logic [9:0]  o_bbox_ymax,
    output logic [18:0] o_lit_count,
    output logic        o_err_sync,
    output logic [1:0]  o_state
);

    localparam logic [9:0] L_HLAST = 10'(HPIXELS - 1);
    localparam logic [9:0] L_VLAST = 10'(VLINES - 1);
    localparam logic [9:0] L_HBP   = 10'(HBP);
    localparam logic [9:0] L_HFP   = 10'(HFP);
    localparam logic [9:0] L_VBP   = 10'(VBP);
    localparam logic [9:0] L_VFP   = 10'(VFP);

    typedef enum logic [1:0] {
        S_SEARCH  = 2'd0,
        S_MEASURE = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_hs_q;
    logic        r_vs_q;
    logic [9:0]  r_hc;
    logic [9:0]  r_vc;

    logic [18:0] r_acc_cnt;
    logic [9:0]  r_acc_xmin;
    logic [9:0]  r_acc_xmax;
    logic [9:0]  r_acc_ymin;
    logic [9:0]  r_acc_ymax;

    logic        w_hfall;
    logic        w_vfall;
    logic [9:0]  w_hc_now;
    logic [9:0]  w_vc_now;
    logic [9:0]  w_px;
    logic [9:0]  w_py;
    logic [7:0]  w_rgb;
    logic        w_viol;
    logic        w_active;
    logic        w_lit;
    logic        w_close;
    logic        w_err;
    logic        w_clr;

    // Every input is qualified by i_pix_en; nothing but the pulses changes on other clocks.
    assign w_hfall = i_pix_en & ~i_hsync & r_hs_q;
    assign w_vfall = i_pix_en & ~i_vsync & r_vs_q;
    assign w_rgb   = {i_red, i_green, i_blue};

    // Coordinates of the sample being taken now; the hfall sample itself is hc=0.
    always_comb begin
        w_hc_now = r_hc + 10'd1;
        w_vc_now = r_vc;
        if (w_hfall) begin
            w_hc_now = '0;
            w_vc_now = w_vfall ? '0 : r_vc + 10'd1;
        end
    end

    assign w_px = w_hc_now - L_HBP;
    assign w_py = w_vc_now - L_VBP;

    always_comb begin
        w_viol = 1'b0;
        if (i_pix_en) begin
            if (w_hfall && r_hc != L_HLAST)                 w_viol = 1'b1;
            if (!w_hfall && r_hc == L_HLAST)                w_viol = 1'b1;
            if (w_vfall && (!w_hfall || r_vc != L_VLAST))   w_viol = 1'b1;
            if (w_hfall && !w_vfall && r_vc == L_VLAST)     w_viol = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hs_q <= 1'b0;
            r_vs_q <= 1'b0;
            r_hc   <= '0;
            r_vc   <= '0;
        end else if (i_pix_en) begin
            r_hs_q <= i_hsync;
            r_vs_q <= i_vsync;
            r_hc   <= w_hc_now;
            r_vc   <= w_vc_now;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_SEARCH;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_SEARCH:  if (w_hfall && w_vfall) w_state_nxt = S_MEASURE;
            S_MEASURE: begin
                if (w_viol)       w_state_nxt = S_SEARCH;
                else if (w_vfall) w_state_nxt = S_LOCKED;
            end
            S_LOCKED:  if (w_viol) w_state_nxt = S_SEARCH;
            default:   w_state_nxt = S_SEARCH;
        endcase
    end

    always_comb begin
        w_active = i_pix_en && (r_state == S_LOCKED) &&
                   (w_hc_now >= L_HBP) && (w_hc_now < L_HFP) &&
                   (w_vc_now >= L_VBP) && (w_vc_now < L_VFP);
        w_lit    = w_active && (w_rgb != 8'd0);
        w_close  = (r_state == S_LOCKED) && w_vfall && !w_viol;
        w_err    = (r_state == S_LOCKED) && w_viol;
        w_clr    = w_vfall || w_viol;
    end

    assign o_locked = (r_state == S_LOCKED);
    assign o_state  = r_state;

    // The first lit pixel of a frame seeds all four bounds.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_clr) begin
            r_acc_cnt  <= '0;
            r_acc_xmin <= '0;
            r_acc_xmax <= '0;
            r_acc_ymin <= '0;
            r_acc_ymax <= '0;
        end else if (w_lit) begin
            r_acc_cnt <= r_acc_cnt + 19'd1;
            if (r_acc_cnt == 19'd0) begin
                r_acc_xmin <= w_px;
                r_acc_xmax <= w_px;
                r_acc_ymin <= w_py;
                r_acc_ymax <= w_py;
            end else begin
                if (w_px < r_acc_xmin) r_acc_xmin <= w_px;
                if (w_px > r_acc_xmax) r_acc_xmax <= w_px;
                if (w_py < r_acc_ymin) r_acc_ymin <= w_py;
                if (w_py > r_acc_ymax) r_acc_ymax <= w_py;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_pix_valid  <= 1'b0;
            o_pix_x      <= '0;
            o_pix_y      <= '0;
            o_pix_rgb    <= '0;
            o_frame_done <= 1'b0;
            o_err_sync   <= 1'b0;
            o_bbox_valid <= 1'b0;
            o_bbox_xmin  <= '0;
            o_bbox_xmax  <= '0;
            o_bbox_ymin  <= '0;
            o_bbox_ymax  <= '0;
            o_lit_count  <= '0;
        end else begin
            o_pix_valid  <= w_active;
            o_frame_done <= w_close;
            o_err_sync   <= w_err;
            if (w_active) begin
                o_pix_x   <= w_px;
                o_pix_y   <= w_py;
                o_pix_rgb <= w_rgb;
            end
            if (w_close) begin
                o_bbox_valid <= (r_acc_cnt != 19'd0);
                o_bbox_xmin  <= r_acc_xmin;
                o_bbox_xmax  <= r_acc_xmax;
                o_bbox_ymin  <= r_acc_ymin;
                o_bbox_ymax  <= r_acc_ymax;
                o_lit_count  <= r_acc_cnt;
            end
        end
    end

endmodule

// File: tb/tb_vga_capture_monitor.sv
// Bench for vga_capture_monitor on a reduced 40x20 raster, driven frame by frame from a
// table of raster descriptions and checked tick by tick against a frame-level reference.
module tb_vga_capture_monitor;

    localparam int HP = 40;
    localparam int VL = 20;
    localparam int HB = 8;
    localparam int HF = 36;
    localparam int VB = 3;
    localparam int VF = 17;
    localparam int HS_W = 4;
    localparam int VS_W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic        hsync;
    logic        vsync;
    logic [2:0]  red;
    logic [2:0]  green;
    logic [1:0]  blue;
    logic        locked;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [7:0]  pix_rgb;
    logic        frame_done;
    logic        bbox_valid;
    logic [9:0]  bbox_xmin;
    logic [9:0]  bbox_xmax;
    logic [9:0]  bbox_ymin;
    logic [9:0]  bbox_ymax;
    logic [18:0] lit_count;
    logic        err_sync;
    logic [1:0]  dbg_state;

    vga_capture_monitor #(
        .HPIXELS(HP), .VLINES(VL), .HBP(HB), .HFP(HF), .VBP(VB), .VFP(VF)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_pix_en(pix_en), .i_hsync(hsync), .i_vsync(vsync),
        .i_red(red), .i_green(green), .i_blue(blue),
        .o_locked(locked), .o_pix_valid(pix_valid), .o_pix_x(pix_x), .o_pix_y(pix_y),
        .o_pix_rgb(pix_rgb), .o_frame_done(frame_done), .o_bbox_valid(bbox_valid),
        .o_bbox_xmin(bbox_xmin), .o_bbox_xmax(bbox_xmax), .o_bbox_ymin(bbox_ymin),
        .o_bbox_ymax(bbox_ymax), .o_lit_count(lit_count), .o_err_sync(err_sync),
        .o_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   nlines;
        int   short_line;
        int   mode;
        int   rst_line;
        int   exp_done;
        int   exp_err;
        logic exp_locked;
    } vec_t;

    vec_t vecs[17];

    int n_pass = 0;
    int n_total = 0;
    int stray = 0;

    // Reference: 0 search, 1 measure (one frame), 2 locked
    int m_state = 0;
    int m_last_len = HP;
    int m_last_lines = VL;
    int st_lit, st_xmin, st_xmax, st_ymin, st_ymax;

    logic e_valid, e_done, e_err, e_locked;
    int   e_x, e_y, e_rgb, e_lit, e_bv, e_xmin, e_xmax, e_ymin, e_ymax;

    int row_done, row_err, row_valid;
    int first_x, first_y, last_x, last_y;
    int d_lit, d_bv, d_xmin, d_xmax, d_ymin, d_ymax;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic clear_stats();
        st_lit = 0; st_xmin = 0; st_xmax = 0; st_ymin = 0; st_ymax = 0;
    endtask

    function automatic logic [7:0] pixel(input int mode, input int h, input int v);
        if (h < HB || h >= HF || v < VB || v >= VF) return 8'd0;
        case (mode)
            1: return ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            2: return (h >= 20 && h <= 23 && v >= 7 && v <= 10) ? 8'hFF : 8'd0;
            default: return 8'd0;
        endcase
    endfunction

    // A line start is an hfall; a frame start is the line start of line 0.
    task automatic model_step(input int h, input int v, input logic [7:0] rgb);
        logic bad;
        e_valid = 1'b0; e_done = 1'b0; e_err = 1'b0;
        if (h == 0) begin
            bad = (m_last_len != HP) || (v == 0 && m_last_lines != VL);
            if (m_state != 0 && bad) begin
                e_err = (m_state == 2);
                m_state = 0;
                clear_stats();
            end else if (v == 0) begin
                if (m_state == 0) m_state = 1;
                else if (m_state == 1) m_state = 2;
                else begin
                    e_done = 1'b1;
                    e_lit = st_lit; e_bv = (st_lit > 0);
                    e_xmin = st_xmin; e_xmax = st_xmax; e_ymin = st_ymin; e_ymax = st_ymax;
                end
                clear_stats();
            end
        end
        if (m_state == 2 && h >= HB && h < HF && v >= VB && v < VF) begin
            e_valid = 1'b1;
            e_x = h - HB; e_y = v - VB; e_rgb = int'(rgb);
            if (rgb != 8'd0) begin
                if (st_lit == 0) begin
                    st_xmin = e_x; st_xmax = e_x; st_ymin = e_y; st_ymax = e_y;
                end else begin
                    if (e_x < st_xmin) st_xmin = e_x;
                    if (e_x > st_xmax) st_xmax = e_x;
                    if (e_y < st_ymin) st_ymin = e_y;
                    if (e_y > st_ymax) st_ymax = e_y;
                end
                st_lit++;
            end
        end
        e_locked = (m_state == 2);
    endtask

    task automatic tick(input logic hs, input logic vs, input logic [7:0] rgb);
        hsync = hs; vsync = vs; {red, green, blue} = rgb; pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
    endtask

    task automatic gap();
        int n;
        n = $urandom_range(0, 2);
        repeat (n) begin
            @(negedge clk);
            if (pix_valid || frame_done || err_sync) stray++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " locked"}, 32'(locked), 0);
        chk({tag, " pix_valid"}, 32'(pix_valid), 0);
        chk({tag, " pix_x/y/rgb"}, {4'd0, pix_x, pix_y, pix_rgb}, 0);
        chk({tag, " frame_done"}, 32'(frame_done), 0);
        chk({tag, " err_sync"}, 32'(err_sync), 0);
        chk({tag, " bbox"}, {bbox_valid, 1'b0, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax}, 0);
        chk({tag, " lit_count"}, 32'(lit_count), 0);
    endtask

    task automatic check_tick();
        chk("locked", 32'(locked), 32'(e_locked));
        chk("pix_valid", 32'(pix_valid), 32'(e_valid));
        chk("frame_done", 32'(frame_done), 32'(e_done));
        chk("err_sync", 32'(err_sync), 32'(e_err));
        if (e_valid) begin
            chk("pix_x", 32'(pix_x), 32'(e_x));
            chk("pix_y", 32'(pix_y), 32'(e_y));
            chk("pix_rgb", 32'(pix_rgb), 32'(e_rgb));
        end
        if (e_done) begin
            chk("lit_count", 32'(lit_count), 32'(e_lit));
            chk("bbox_valid", 32'(bbox_valid), 32'(e_bv));
            chk("bbox_xmin", 32'(bbox_xmin), 32'(e_xmin));
            chk("bbox_xmax", 32'(bbox_xmax), 32'(e_xmax));
            chk("bbox_ymin", 32'(bbox_ymin), 32'(e_ymin));
            chk("bbox_ymax", 32'(bbox_ymax), 32'(e_ymax));
        end
        if (frame_done) begin
            row_done++;
            d_lit = int'(lit_count); d_bv = int'(bbox_valid);
            d_xmin = int'(bbox_xmin); d_xmax = int'(bbox_xmax);
            d_ymin = int'(bbox_ymin); d_ymax = int'(bbox_ymax);
        end
        if (err_sync) row_err++;
        if (pix_valid) begin
            if (row_valid == 0) begin
                first_x = int'(pix_x); first_y = int'(pix_y);
            end
            last_x = int'(pix_x); last_y = int'(pix_y);
            row_valid++;
        end
    endtask

    task automatic mid_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("mid-reset");
        m_state = 0;
        clear_stats();
    endtask

    task automatic run_frame(input vec_t t);
        int len;
        logic [7:0] rgb;
        for (int v = 0; v < t.nlines; v++) begin
            len = (v == t.short_line) ? HP - 1 : HP;
            for (int h = 0; h < len; h++) begin
                if (v == t.rst_line && h == 10) mid_reset();
                rgb = pixel(t.mode, h, v);
                model_step(h, v, rgb);
                tick(h >= HS_W, v >= VS_W, rgb);
                check_tick();
                gap();
            end
            m_last_len = len;
        end
        m_last_lines = t.nlines;
    endtask

    initial begin
        //          nlines  short mode rst  done err locked
        vecs[0]  = '{VL,     -1,   0,   -1,  0,   0,  1'b0};
        vecs[1]  = '{VL,     -1,   0,   -1,  0,   0,  1'b1};
        vecs[2]  = '{VL,     -1,   0,   -1,  1,   0,  1'b1};
        vecs[3]  = '{VL,     -1,   2,   -1,  1,   0,  1'b1};
        vecs[4]  = '{VL,     -1,   1,   -1,  1,   0,  1'b1};
        vecs[5]  = '{VL,      5,   1,   -1,  1,   1,  1'b0};
        vecs[6]  = '{VL,     -1,   1,   -1,  0,   0,  1'b0};
        vecs[7]  = '{VL,     -1,   1,   -1,  0,   0,  1'b1};
        vecs[8]  = '{VL - 1, -1,   1,   -1,  1,   0,  1'b1};
        vecs[9]  = '{VL,     -1,   1,   -1,  0,   1,  1'b0};
        vecs[10] = '{VL,     -1,   1,   -1,  0,   0,  1'b0};
        vecs[11] = '{VL,     -1,   1,   -1,  0,   0,  1'b1};
        vecs[12] = '{VL,     -1,   1,   -1,  1,   0,  1'b1};
        vecs[13] = '{VL,     -1,   1,    9,  1,   0,  1'b0};
        vecs[14] = '{VL,     -1,   1,   -1,  0,   0,  1'b0};
        vecs[15] = '{VL,     -1,   1,   -1,  0,   0,  1'b1};
        vecs[16] = '{VL,     -1,   1,   -1,  1,   0,  1'b1};

        rst = 1'b1; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1;
        red = '0; green = '0; blue = '0;
        clear_stats();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b1, 8'd0);
            chk("idle locked", 32'(locked), 0);
            chk("idle pulses", {29'd0, pix_valid, frame_done, err_sync}, 0);
            gap();
        end
        check_all_zero("idle");

        for (int i = 0; i < 17; i++) begin
            row_done = 0; row_err = 0; row_valid = 0;
            run_frame(vecs[i]);
            chk($sformatf("row%0d frame_done count", i), 32'(row_done), 32'(vecs[i].exp_done));
            chk($sformatf("row%0d err_sync count", i), 32'(row_err), 32'(vecs[i].exp_err));
            chk($sformatf("row%0d locked at end", i), 32'(locked), 32'(vecs[i].exp_locked));
            if (i == 2) begin
                chk("black frame pix_valid count", 32'(row_valid), 32'((HF - HB) * (VF - VB)));
                chk("first pixel x,y", {16'(first_x), 16'(first_y)}, {16'd0, 16'd0});
                chk("last pixel x,y", {16'(last_x), 16'(last_y)},
                    {16'(HF - HB - 1), 16'(VF - VB - 1)});
            end
            if (i == 3) begin
                chk("black frame lit_count", 32'(d_lit), 0);
                chk("black frame bbox_valid", 32'(d_bv), 0);
            end
            if (i == 4) begin
                chk("block lit_count", 32'(d_lit), 16);
                chk("block bbox_valid", 32'(d_bv), 1);
                chk("block xmin/xmax", {16'(d_xmin), 16'(d_xmax)}, {16'd12, 16'd15});
                chk("block ymin/ymax", {16'(d_ymin), 16'(d_ymax)}, {16'd4, 16'd7});
            end
        end

        chk("pulses on idle clocks", 32'(stray), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
